// File: rtl/ctrl_mem_loader.sv
// Control-memory loader: assembles narrow configuration bus words into
// CTRL_W-bit control entries and writes them to consecutive addresses from 0.
module ctrl_mem_loader #(
  parameter int CTRL_W   = 49,
  parameter int WORD_W   = 32,
  parameter int MEM_SIZE = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic [ADDR_W:0]     cfg_num,
  input  logic                recv_word__en,
  input  logic [WORD_W-1:0]   recv_word__msg,
  output logic                recv_word__rdy,
  output logic [ADDR_W-1:0]   send_waddr__msg,
  output logic [CTRL_W-1:0]   send_ctrl__msg,
  output logic                send_ctrl__en,
  input  logic                send_ctrl__rdy,
  output logic                busy,
  output logic                done
);

  localparam int BEATS  = (CTRL_W + WORD_W - 1) / WORD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    FINISH
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    count;
  logic [CTRL_W-1:0]   asm_q;

  logic [CTRL_W-1:0]   asm_next;
  logic [CTRL_W-1:0]   word_ext;
  logic [CTRL_W-1:0]   word_mask;
  logic [31:0]         shamt;
  logic [CNT_W-1:0]    num_clamped;
  logic                word_fire;
  logic                last_beat;
  logic                last_entry;

  assign word_fire   = recv_word__en && recv_word__rdy;
  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign last_entry  = (({1'b0, addr} + CNT_W'(1)) == count);
  assign num_clamped = (cfg_num > CNT_W'(MEM_SIZE)) ? CNT_W'(MEM_SIZE) : cfg_num;

  // The write strobe follows the memory's ready combinationally so a
  // stalled entry fires on the very first cycle the memory can take it.
  assign send_ctrl__en = (state == WRITE) && send_ctrl__rdy;

  // Merge the incoming word into its slice of the entry; bits shifted past
  // CTRL_W fall off, which drops the unused top of the final word.
  assign word_ext  = CTRL_W'(recv_word__msg);
  assign word_mask = CTRL_W'({WORD_W{1'b1}});

  // NOTE: combinational blocks assign every output before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    shamt    = 32'(beat) * 32'(WORD_W);
    asm_next = (asm_q & ~(word_mask << shamt)) | (word_ext << shamt);
  end

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      beat            <= '0;
      addr            <= '0;
      count           <= '0;
      asm_q           <= '0;
      recv_word__rdy  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      send_waddr__msg <= '0;
      send_ctrl__msg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            busy <= 1'b1;
            if (cfg_num == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state          <= LOAD;
              count          <= num_clamped;
              addr           <= '0;
              beat           <= '0;
              recv_word__rdy <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (word_fire) begin
            asm_q <= asm_next;
            if (last_beat) begin
              beat            <= '0;
              state           <= WRITE;
              recv_word__rdy  <= 1'b0;
              send_ctrl__msg  <= asm_next;
              send_waddr__msg <= addr;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end

        WRITE: begin
          if (send_ctrl__rdy) begin
            if (last_entry) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              addr           <= addr + ADDR_W'(1);
              state          <= LOAD;
              recv_word__rdy <= 1'b1;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          recv_word__rdy <= 1'b0;
          done           <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
